systolic_operand_sequencer: RTL and testbench

//   Upstream feeder for the systolic input skew controller. On a start command, fetches k_len

---
 rtl/systolic_operand_sequencer.sv | 87 ++++++++
 tb/tb_systolic_operand_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/systolic_operand_sequencer.sv
// systolic_operand_sequencer: fetches k_len A/B operand vectors, presents them to the skew controller, then flushes the array with zero vectors
module systolic_operand_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH:0]        k_len,
    input  logic [ADDR_WIDTH-1:0]      a_base,
    input  logic [ADDR_WIDTH-1:0]      b_base,
    output logic                       a_rd_en,
    output logic [ADDR_WIDTH-1:0]      a_rd_addr,
    input  logic [DATA_WIDTH*ROWS-1:0] a_rd_data,
    output logic                       b_rd_en,
    output logic [ADDR_WIDTH-1:0]      b_rd_addr,
    input  logic [DATA_WIDTH*COLS-1:0] b_rd_data,
    output logic [DATA_WIDTH*ROWS-1:0] a_vec,
    output logic [DATA_WIDTH*COLS-1:0] b_vec,
    output logic                       vec_en,
    output logic                       busy,
    output logic                       done
);
    localparam int FLUSH_CYCLES = ROWS + COLS;
    localparam int FW = $clog2(FLUSH_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
    state_t              state;
    logic [ADDR_WIDTH:0] rd_cnt;
    logic [FW-1:0]       fl_cnt;
    assign b_rd_en = a_rd_en;
    assign a_vec = vec_en ? a_rd_data : '0;
    assign b_vec = vec_en ? b_rd_data : '0;
    // job FSM: read strobes/addresses, operand-valid delay, flush countdown and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
            rd_cnt    <= '0;
            fl_cnt    <= '0;
            vec_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vec_en <= a_rd_en;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (k_len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= READ;
                        a_rd_en   <= 1'b1;
                        a_rd_addr <= a_base;
                        b_rd_addr <= b_base;
                        rd_cnt    <= k_len - 1'b1;
                    end
                end
                READ: if (rd_cnt == '0) begin
                    state   <= FLUSH;
                    a_rd_en <= 1'b0;
                    fl_cnt  <= FW'(FLUSH_CYCLES);
                end else begin
                    rd_cnt    <= rd_cnt - 1'b1;
                    a_rd_addr <= a_rd_addr + 1'b1;
                    b_rd_addr <= b_rd_addr + 1'b1;
                end
                FLUSH: if (fl_cnt == '0) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    fl_cnt <= fl_cnt - 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_operand_sequencer.sv
// tb_systolic_operand_sequencer: directed job table plus reset-abort sequence against a cycle-accurate expectation
module tb_systolic_operand_sequencer;
    localparam int DW = 8;
    localparam int R = 8;
    localparam int C = 8;
    localparam int AW = 8;
    localparam int F = R + C;

    logic            clk, rst, start;
    logic [AW:0]     k_len;
    logic [AW-1:0]   a_base, b_base, a_rd_addr, b_rd_addr;
    logic            a_rd_en, b_rd_en, vec_en, busy, done;
    logic [DW*R-1:0] a_rd_data, a_vec;
    logic [DW*C-1:0] b_rd_data, b_vec;
    int              errors = 0;
    int              checks = 0;

    systolic_operand_sequencer #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_base(a_base), .b_base(b_base),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .a_vec(a_vec), .b_vec(b_vec), .vec_en(vec_en), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A[k]: every lane k+1; B[k]: lane c = 3k+c+128 (mixed signs, lane-distinct)
    function automatic logic [DW*R-1:0] a_word(input int addr);
        logic [DW*R-1:0] w;
        for (int r = 0; r < R; r++) w[r*DW +: DW] = 8'((addr % 256) + 1);
        return w;
    endfunction

    function automatic logic [DW*C-1:0] b_word(input int addr);
        logic [DW*C-1:0] w;
        for (int c = 0; c < C; c++) w[c*DW +: DW] = 8'((addr % 256) * 3 + c + 128);
        return w;
    endfunction

    // one-cycle-latency operand buffers
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_word(int'(a_rd_addr));
        if (b_rd_en) b_rd_data <= b_word(int'(b_rd_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int kl;
        int ab;
        int bb;
        int p0;
        int p1;
        int p2;
        int exp_done;
        int exp_vec;
    } vec_t;

    vec_t tbl[7];

    // caller is at a negedge; start is driven for cycle 0, outputs sampled on negedges of cycles 1..D+1
    task automatic run_job(input vec_t v);
        int d_cyc, n_done, n_vec, n_rd, e_rd, e_vec, e_busy, dc;
        logic rd, ev;
        logic [DW*R-1:0] ea;
        logic [DW*C-1:0] eb;
        d_cyc = -1; n_done = 0; n_vec = 0; n_rd = 0; e_rd = 0; e_vec = 0; e_busy = 0;
        dc = (v.kl == 0) ? 1 : v.kl + F + 2;
        k_len = 9'(v.kl);
        a_base = 8'(v.ab);
        b_base = 8'(v.bb);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk);
            rd = (c <= v.kl);
            ev = (c >= 2) && (c <= v.kl + 1);
            ea = ev ? a_word(v.ab + c - 2) : '0;
            eb = ev ? b_word(v.bb + c - 2) : '0;
            if (a_rd_en) n_rd++;
            if (vec_en) n_vec++;
            if (done) begin
                n_done++;
                if (d_cyc < 0) d_cyc = c;
            end
            if (a_rd_en !== rd || b_rd_en !== rd ||
                (rd && (a_rd_addr !== 8'(v.ab + c - 1) || b_rd_addr !== 8'(v.bb + c - 1)))) e_rd++;
            if (vec_en !== ev || a_vec !== ea || b_vec !== eb) e_vec++;
            if (busy !== (c <= dc) || done !== (c == dc)) e_busy++;
            start = (c == v.p0 || c == v.p1 || c == v.p2);
        end
        start = 1'b0;
        check($sformatf("done_cycle k=%0d", v.kl), 64'(d_cyc), 64'(v.exp_done));
        check($sformatf("done_pulses k=%0d", v.kl), 64'(n_done), 64'd1);
        check($sformatf("vec_en_cycles k=%0d", v.kl), 64'(n_vec), 64'(v.exp_vec));
        check($sformatf("rd_cycles k=%0d", v.kl), 64'(n_rd), 64'(v.kl));
        check($sformatf("rd_seq_errs k=%0d", v.kl), 64'(e_rd), 64'd0);
        check($sformatf("vec_data_errs k=%0d", v.kl), 64'(e_vec), 64'd0);
        check($sformatf("busy_done_errs k=%0d", v.kl), 64'(e_busy), 64'd0);
    endtask

    initial begin
        int n_done;
        vec_t fresh;
        tbl[0] = '{4,   8'h00, 8'h10, 0, 0,  0,  22,  4};
        tbl[1] = '{0,   8'h00, 8'h00, 0, 0,  0,  1,   0};
        tbl[2] = '{4,   8'hFE, 8'h20, 0, 0,  0,  22,  4};
        tbl[3] = '{1,   8'h05, 8'hFF, 0, 0,  0,  19,  1};
        tbl[4] = '{256, 8'h00, 8'h80, 0, 0,  0,  274, 256};
        tbl[5] = '{4,   8'h30, 8'h40, 3, 10, 22, 22,  4};
        tbl[6] = '{2,   8'h60, 8'h70, 0, 0,  0,  20,  2};
        rst = 1'b1; start = 1'b0; k_len = '0; a_base = '0; b_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst a_rd_en", 64'(a_rd_en), 64'd0);
        check("rst b_rd_en", 64'(b_rd_en), 64'd0);
        check("rst a_rd_addr", 64'(a_rd_addr), 64'd0);
        check("rst vec_en", 64'(vec_en), 64'd0);
        check("rst a_vec", 64'(a_vec), 64'd0);
        check("rst b_vec", 64'(b_vec), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) run_job(tbl[i]);
        k_len = 9'd8; a_base = 8'h00; b_base = 8'h00; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort pre rd_en", 64'(a_rd_en), 64'd1);
        check("abort pre busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort a_rd_en", 64'(a_rd_en), 64'd0);
        check("abort a_rd_addr", 64'(a_rd_addr), 64'd0);
        check("abort b_rd_addr", 64'(b_rd_addr), 64'd0);
        check("abort vec_en", 64'(vec_en), 64'd0);
        check("abort a_vec", 64'(a_vec), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("abort no done/busy", 64'(n_done), 64'd0);
        fresh = '{8, 8'h10, 8'h20, 0, 0, 0, 26, 8};
        run_job(fresh);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
